// File: rtl/axis_display_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axis_display_if : X/Y/Z accelerometer word bus into the display scanner |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface axis_display_if #(
  parameter int NDIG = 4
);
  logic                data_vld;
  logic [4*NDIG-1:0]   x_data;
  logic [4*NDIG-1:0]   y_data;
  logic [4*NDIG-1:0]   z_data;

  modport master (output data_vld, x_data, y_data, z_data);
  modport slave  (input  data_vld, x_data, y_data, z_data);
endinterface
`default_nettype wire

// File: rtl/axis_display_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | axis_display_scanner : multiplexed seven-segment driver for X/Y/Z words |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module axis_display_scanner #(
  parameter int NDIG     = 4,
  parameter int NAXIS    = 3,
  parameter int BLANK_LZ = 0
) (
  input  wire logic            clk,
  input  wire logic            arstn,
  input  wire logic            scan_div,
  input  wire logic            sel_div,
  input  wire logic            hold,
  axis_display_if.slave        bus,
  output logic [NDIG-1:0]      an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [1:0]           axis_id
);

  localparam int c_DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int c_WORD_W = 4 * NDIG;

  typedef enum logic [1:0] {
    AX_X = 2'd0,
    AX_Y = 2'd1,
    AX_Z = 2'd2
  } axis_e;

  axis_e                r_state;
  axis_e                w_state_nxt;
  axis_e                w_load_sel;
  logic                 r_scan_prev;
  logic                 r_sel_prev;
  logic                 r_run;
  logic [c_DIG_W-1:0]   r_digit;
  logic [c_WORD_W-1:0]  r_snap;
  logic [c_WORD_W-1:0]  w_word;
  logic [NDIG-1:0]      w_upper_zero;
  logic                 w_scan_edge;
  logic                 w_sel_edge;
  logic                 w_adv;
  logic [3:0]           w_nib;
  logic                 w_blank;
  logic                 w_dp_on;

  function automatic logic [6:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0: f_hex = 7'h40;  4'h1: f_hex = 7'h79;  4'h2: f_hex = 7'h24;  4'h3: f_hex = 7'h30;
      4'h4: f_hex = 7'h19;  4'h5: f_hex = 7'h12;  4'h6: f_hex = 7'h02;  4'h7: f_hex = 7'h78;
      4'h8: f_hex = 7'h00;  4'h9: f_hex = 7'h10;  4'hA: f_hex = 7'h08;  4'hB: f_hex = 7'h03;
      4'hC: f_hex = 7'h46;  4'hD: f_hex = 7'h21;  4'hE: f_hex = 7'h06;  default: f_hex = 7'h0E;
    endcase
  endfunction

  assign w_scan_edge = scan_div & ~r_scan_prev;
  assign w_sel_edge  = sel_div & ~r_sel_prev;
  assign w_adv       = w_sel_edge & ~hold;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AX_X:    if (w_adv) w_state_nxt = (NAXIS > 1) ? AX_Y : AX_X;
      AX_Y:    if (w_adv) w_state_nxt = (NAXIS > 2) ? AX_Z : AX_X;
      AX_Z:    if (w_adv) w_state_nxt = AX_X;
      default: w_state_nxt = AX_X;
    endcase
  end

  // An advance loads the incoming axis; otherwise data_vld refreshes the current one.
  always_comb begin
    w_load_sel = w_adv ? w_state_nxt : r_state;
    case (w_load_sel)
      AX_Y:    w_word = bus.y_data;
      AX_Z:    w_word = bus.z_data;
      default: w_word = bus.x_data;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_scan_prev <= 1'b1;
      r_sel_prev  <= 1'b1;
      r_state     <= AX_X;
      r_run       <= 1'b0;
      r_digit     <= '0;
      r_snap      <= '0;
    end else begin
      r_scan_prev <= scan_div;
      r_sel_prev  <= sel_div;
      r_state     <= w_state_nxt;
      if (w_adv || bus.data_vld)
        r_snap <= w_word;
      // The first scan edge after reset lights digit 0; later edges step the digit.
      if (w_scan_edge) begin
        if (!r_run)
          r_run <= 1'b1;
        else if (r_digit == c_DIG_W'(NDIG - 1))
          r_digit <= '0;
        else
          r_digit <= r_digit + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_lz
    assign w_upper_zero[k] = ~|r_snap[c_WORD_W-1:4*k];
  end

  assign w_nib   = r_snap[4*r_digit +: 4];
  assign w_blank = (BLANK_LZ != 0) && (r_digit != '0) && w_upper_zero[r_digit];
  assign w_dp_on = (32'(r_digit) == 32'(r_state));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      an      <= '1;
      seg     <= 7'h7F;
      dp      <= 1'b1;
      axis_id <= 2'd0;
    end else begin
      axis_id <= r_state;
      if (r_run) begin
        an  <= ~(NDIG'(1) << r_digit);
        seg <= w_blank ? 7'h7F : f_hex(w_nib);
        dp  <= ~w_dp_on;
      end else begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_display_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_axis_display_scanner : directed bench for axis_display_scanner       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_axis_display_scanner;

  logic       clk;
  logic       arstn;
  logic       scan_div;
  logic       sel_div;
  logic       hold;
  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [1:0] ax0, ax1;
  int         n_tests;
  int         n_fail;

  axis_display_if #(.NDIG(4)) bus ();

  axis_display_scanner #(.NDIG(4), .NAXIS(3), .BLANK_LZ(0)) dut0 (
    .clk(clk), .arstn(arstn), .scan_div(scan_div), .sel_div(sel_div), .hold(hold),
    .bus(bus), .an(an0), .seg(seg0), .dp(dp0), .axis_id(ax0)
  );

  axis_display_scanner #(.NDIG(4), .NAXIS(3), .BLANK_LZ(1)) dut1 (
    .clk(clk), .arstn(arstn), .scan_div(scan_div), .sel_div(sel_div), .hold(hold),
    .bus(bus), .an(an1), .seg(seg1), .dp(dp1), .axis_id(ax1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise the selected inputs for one sampled cycle, then let outputs settle.
  task automatic pulse(input logic s, input logic a, input logic v);
    scan_div     = s;
    sel_div      = a;
    bus.data_vld = v;
    tick();
    scan_div     = 1'b0;
    sel_div      = 1'b0;
    bus.data_vld = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [3:0] exp_an[4];
    logic [6:0] exp_seg[4];
    n_tests = 0;
    n_fail  = 0;
    arstn = 1'b0; scan_div = 1'b1; sel_div = 1'b1; hold = 1'b0;
    bus.data_vld = 1'b0; bus.x_data = '0; bus.y_data = '0; bus.z_data = '0;
    tick(); tick();
    check("rst_an", an0, 4'hF);
    check("rst_seg", seg0, 7'h7F);
    arstn = 1'b1;
    tick(); tick(); tick();
    check("rel_an", an0, 4'hF);
    check("rel_seg", seg0, 7'h7F);
    check("rel_dp", dp0, 1'b1);
    check("rel_axis", ax0, 2'd0);
    scan_div = 1'b0; sel_div = 1'b0;
    tick(); tick();
    check("fall_an", an0, 4'hF);
    check("fall_axis", ax0, 2'd0);

    // Digit scan of 1A2F
    bus.x_data = 16'h1A2F;
    pulse(1'b0, 1'b0, 1'b1);
    exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_seg = '{7'h0E, 7'h24, 7'h08, 7'h79};
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      check($sformatf("scan_an%0d", i), an0, exp_an[i]);
      check($sformatf("scan_seg%0d", i), seg0, exp_seg[i]);
      check($sformatf("scan_dp%0d", i), dp0, (i == 0) ? 1'b0 : 1'b1);
    end
    pulse(1'b1, 1'b0, 1'b0);
    check("wrap_an", an0, 4'hE);

    // Axis rotation on digit 0
    bus.x_data = 16'h1111; bus.y_data = 16'h2222; bus.z_data = 16'h3333;
    pulse(1'b0, 1'b1, 1'b0); check("rot1_axis", ax0, 2'd1); check("rot1_seg", seg0, 7'h24);
    pulse(1'b0, 1'b1, 1'b0); check("rot2_axis", ax0, 2'd2); check("rot2_seg", seg0, 7'h30);
    pulse(1'b0, 1'b1, 1'b0); check("rot3_axis", ax0, 2'd0); check("rot3_seg", seg0, 7'h79);
    pulse(1'b0, 1'b1, 1'b0); check("rot4_axis", ax0, 2'd1); check("rot4_seg", seg0, 7'h24);
    check("rot4_dp", dp0, 1'b1);
    hold = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("hold_axis", ax0, 2'd1);
    hold = 1'b0;
    tick(); tick();
    check("noqueue_axis", ax0, 2'd1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("back_x_axis", ax0, 2'd0);

    // Coincident scan and sel at digit 3
    pulse(1'b1, 1'b0, 1'b0); pulse(1'b1, 1'b0, 1'b0); pulse(1'b1, 1'b0, 1'b0);
    check("d3_an", an0, 4'h7);
    bus.y_data = 16'h00C0;
    scan_div = 1'b1; sel_div = 1'b1;
    tick();
    scan_div = 1'b0; sel_div = 1'b0;
    tick();
    check("coin_an", an0, 4'hE);
    check("coin_axis", ax0, 2'd1);
    check("coin_seg", seg0, 7'h40);
    pulse(1'b1, 1'b0, 1'b0);
    check("coin_next_an", an0, 4'hD);
    check("coin_next_seg", seg0, 7'h46);

    // Snapshot isolation: back to X with 1234 on digit 1
    bus.x_data = 16'h1234;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("snap_axis", ax0, 2'd0);
    check("snap_seg1", seg0, 7'h30);
    bus.x_data = 16'hABCD;
    pulse(1'b1, 1'b0, 1'b0);
    check("snap_hold_seg2", seg0, 7'h24);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check("snap_new_seg3", seg0, 7'h08);
    bus.y_data = 16'h5678;
    pulse(1'b0, 1'b1, 1'b1);
    check("vld_sel_axis", ax0, 2'd1);
    check("vld_sel_seg3", seg0, 7'h12);

    // Leading-zero blanking, currently at digit 3, axis Y
    bus.x_data = 16'h0030;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("lz_axis", ax1, 2'd0);
    check("lz_d3_an", an1, 4'h7);
    check("lz_d3_seg", seg1, 7'h7F);
    check("nolz_d3_seg", seg0, 7'h40);
    pulse(1'b1, 1'b0, 1'b0); check("lz_d0_seg", seg1, 7'h40);
    pulse(1'b1, 1'b0, 1'b0); check("lz_d1_seg", seg1, 7'h30);
    pulse(1'b1, 1'b0, 1'b0); check("lz_d2_seg", seg1, 7'h7F);
    check("lz_d2_an", an1, 4'hB);
    check("nolz_d2_seg", seg0, 7'h40);

    // Asynchronous reset mid-scan
    @(posedge clk);
    #2;
    arstn = 1'b0;
    #1;
    check("arst_an", an0, 4'hF);
    check("arst_seg", seg0, 7'h7F);
    check("arst_dp", dp0, 1'b1);
    check("arst_axis", ax1, 2'd0);
    #2;
    arstn = 1'b1;
    tick(); tick();
    check("arst_rel_an", an0, 4'hF);
    pulse(1'b1, 1'b0, 1'b0);
    check("restart_an", an0, 4'hE);
    check("restart_seg", seg0, 7'h40);
    check("restart_dp", dp0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
